// File: rtl/tile_write_arbiter_pkg.sv
// Shared types and constants for the tile grid write-port scheduler.
package tile_write_arbiter_pkg;

    localparam int GRID_W_DEF = 15;
    localparam int GRID_H_DEF = 15;
    localparam int ADDR_W_DEF = 8;

    typedef logic [3:0] coord_t;
    typedef logic [1:0] tile_t;

    localparam tile_t TILE_WORLD = 2'b00;
    localparam tile_t TILE_FOOD  = 2'b01;
    localparam tile_t TILE_SNAKE = 2'b10;

    typedef enum logic {CLEAR, SERVE} state_t;
    typedef enum logic {SRC_BODY = 1'b0, SRC_FOOD = 1'b1} src_t;

endpackage

// File: rtl/tile_write_arbiter_if.sv
// Requester handshakes and the registered memory write port of the tile arbiter.
interface tile_write_arbiter_if
    import tile_write_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              req_body;
    coord_t            body_x;
    coord_t            body_y;
    tile_t             body_data;
    logic              gnt_body;

    logic              req_food;
    coord_t            food_x;
    coord_t            food_y;
    tile_t             food_data;
    logic              gnt_food;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    tile_t             mem_wdata;

    modport master (
        output req_body, body_x, body_y, body_data,
        output req_food, food_x, food_y, food_data,
        input  gnt_body, gnt_food,
        input  mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_body, body_x, body_y, body_data,
        input  req_food, food_x, food_y, food_data,
        output gnt_body, gnt_food,
        output mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/tile_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: bit 0 = body, bit 1 = food; ties go to the source not granted last.
module tile_write_arbiter_rr_arb2
    import tile_write_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    src_t last_q;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_q == SRC_FOOD) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            last_q <= SRC_FOOD;
        else if (|gnt)
            last_q <= gnt[1] ? SRC_FOOD : SRC_BODY;
    end
endmodule

// File: rtl/tile_write_arbiter.sv
// Single write-port scheduler for the tile grid: auto-clear sweep, then round-robin body/food writes.
// Optional macro VBLANK_GATE_EN restricts sweep writes and grants to cycles with vblank=1.
module tile_write_arbiter
    import tile_write_arbiter_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_start,
    input  logic                 vblank,
    tile_write_arbiter_if.slave  bus,
    output logic                 clear_busy,
    output logic                 err_oob
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GRID_W * GRID_H - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    tile_t             wdata_d;
    logic              oob_set;
    logic              gate;
    logic              arb_en;
    logic [1:0]        gnt;
    coord_t            sel_x, sel_y;
    tile_t             sel_data;
    logic              in_range;
    logic [ADDR_W-1:0] wr_addr;

`ifdef VBLANK_GATE_EN
    assign gate = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign gate          = 1'b1;
`endif

    // clear_start pre-empts any grant in the same SERVE cycle.
    assign arb_en = !reset && (state_q == SERVE) && !clear_start && gate;

    tile_write_arbiter_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en),
        .req   ({bus.req_food, bus.req_body}),
        .gnt   (gnt)
    );

    assign bus.gnt_body = gnt[0];
    assign bus.gnt_food = gnt[1];

    assign sel_x    = gnt[1] ? bus.food_x    : bus.body_x;
    assign sel_y    = gnt[1] ? bus.food_y    : bus.body_y;
    assign sel_data = gnt[1] ? bus.food_data : bus.body_data;
    assign in_range = (int'(sel_x) < GRID_W) && (int'(sel_y) < GRID_H);
    assign wr_addr  = ADDR_W'(sel_y) * ADDR_W'(GRID_W) + ADDR_W'(sel_x);

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        we_d      = 1'b0;
        addr_d    = bus.mem_addr;
        wdata_d   = bus.mem_wdata;
        oob_set   = 1'b0;
        unique case (state_q)
            CLEAR: begin
                if (gate) begin
                    we_d      = 1'b1;
                    addr_d    = clr_ptr_q;
                    wdata_d   = TILE_WORLD;
                    clr_ptr_d = clr_ptr_q + 1'b1;
                    if (clr_ptr_q == LAST_ADDR)
                        state_d = SERVE;
                end
                if (clear_start) begin
                    clr_ptr_d = '0;
                    state_d   = CLEAR;
                end
            end
            SERVE: begin
                if (clear_start) begin
                    clr_ptr_d = '0;
                    state_d   = CLEAR;
                end else if (|gnt) begin
                    // Out-of-range coordinates are still granted so the requester never stalls.
                    if (in_range) begin
                        we_d    = 1'b1;
                        addr_d  = wr_addr;
                        wdata_d = sel_data;
                    end else begin
                        oob_set = 1'b1;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= CLEAR;
            clr_ptr_q     <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= TILE_WORLD;
            err_oob       <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_ptr_q     <= clr_ptr_d;
            bus.mem_we    <= we_d;
            bus.mem_addr  <= addr_d;
            bus.mem_wdata <= wdata_d;
            if (oob_set)
                err_oob <= 1'b1;
        end
    end

    assign clear_busy = (state_q == CLEAR);
endmodule
